mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: MEM_WAIT_MAX, default 15, max memory wait cycles before timeout abort (range 1..255).
REQ-002 Parameter: ALU_CNTL_W, default 4, ALU control width; codes occupy the low 4 bits, upper bits are 0.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 op  in  6  opcode from the instruction register.
REQ-006 func  in  6  R-type function field.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory completion strobe.
REQ-009 Outputs, 1 bit each: pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a (0=PC, 1=A).
REQ-010 alu_src_b  out  2  B operand select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-011 alu_cntl  out  ALU_CNTL_W  ALU operation code.
REQ-012 pc_source  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-013 state  out  4  current FSM state encoding.
REQ-014 instr_done  out  1  one-cycle pulse in the final cycle of each completed instruction.
REQ-015 illegal_op  out  1  one-cycle pulse in DECODE on an unsupported op or func.
REQ-016 mem_timeout  out  1  sticky flag; cleared only by reset.

Function
REQ-017 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BRANCH=8, IEXE=9, IWB=10, JUMP=11; codes 12-15 are unreachable and recover to FETCH.
REQ-018 FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_cntl=0010, pc_source=00, pc_en=1; then go to DECODE.
REQ-019 DECODE: latch op/func internally; alu_src_a=0, alu_src_b=11, alu_cntl=0010 (branch target).
REQ-020 DECODE dispatch: op 00 goes to RTEXE; 08/09/0C/0D/0A/0B go to IEXE; 23/2B go to MEMADR; 04/05 go to BRANCH; 02 goes to JUMP; any other op pulses illegal_op and returns to FETCH.
REQ-021 R-type func to alu_cntl: 20→1010, 21→0010, 22→1110, 23→0110, 24→0000, 25→0001, 26→0011, 27→1100, 2A→1101, 2B→1111; any other func pulses illegal_op and returns to FETCH.
REQ-022 IEXE: alu_src_a=1, alu_src_b=10; alu_cntl by op: 08→1010, 09→0010, 0C→0000, 0D→0001, 0A→1101, 0B→1111.
REQ-023 RTEXE: alu_src_a=1, alu_src_b=00. RTWB: reg_write=1, reg_dst=1. IWB: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-024 MEMADR: alu_src_a=1, alu_src_b=10, alu_cntl=0010; go to MEMRD for op 23 or MEMWR for op 2B.
REQ-025 MEMRD: mem_read=1, iord=1. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. MEMWR: mem_write=1, iord=1.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_cntl=0110, pc_source=01; pc_en=zero for op 04, pc_en=~zero for op 05.
REQ-027 JUMP: pc_source=10, pc_en=1.
REQ-028 All signals not listed for a state are 0.
REQ-029 instr_done asserts in RTWB, IWB, MEMWB, MEMWR, BRANCH and JUMP; the next state is FETCH.
REQ-030 Zero-wait latency in cycles, FETCH to done inclusive: R-type 4, I-ALU 4, lw 5, sw 4, beq/bne 3, j 3.

Reset
REQ-031 While reset_n=0: state=FETCH and every output is 0, including pc_en, ir_write and mem_read.
REQ-032 Reset asserted mid-instruction aborts the instruction immediately; there is no partial register or memory write after assertion and instr_done does not pulse.
REQ-033 The first rising edge after reset_n rises executes FETCH.

Configuration
REQ-034 Macro MC_CONTROL_MEMWAIT_EN compiles the memory wait-state handshake in or out.
REQ-035 With MC_CONTROL_MEMWAIT_EN defined:
- FETCH, MEMRD and MEMWR hold until mem_ready=1.
- In FETCH, ir_write and pc_en assert only in the mem_ready cycle.
- A wait counter clears on state entry.
- If MEM_WAIT_MAX cycles elapse with mem_ready=0, mem_timeout is set and the FSM goes to FETCH with no instr_done. A timeout in FETCH restarts FETCH.
- mem_ready=1 in the same cycle as the counter limit counts as success.
REQ-036 Without MC_CONTROL_MEMWAIT_EN: mem_ready is ignored, each memory state lasts one cycle, and mem_timeout is tied to 0.

Verification
REQ-037 add (op 00, func 20) → states 0,1,6,7; alu_cntl=1010 in RTEXE; reg_write=1, reg_dst=1 in RTWB; instr_done in cycle 4.
REQ-038 lw (op 23) → states 0,1,2,3,4; mem_read=1, iord=1 in MEMRD; mem_to_reg=1 in MEMWB; sw (op 2B) → mem_write=1 in cycle 4, reg_write never 1.
REQ-039 beq with zero=1 → pc_en=1 in BRANCH; beq with zero=0 → pc_en=0; bne inverts both; j (op 02) → pc_source=10, pc_en=1 in cycle 3.
REQ-040 op 3F, then add func 3F → illegal_op pulses once in DECODE, FETCH follows, no reg_write.
REQ-041 MEMWAIT_EN with MEM_WAIT_MAX=15: mem_ready low 3 cycles in MEMRD → lw completes in 8 cycles; mem_ready held low → mem_timeout=1 after 15 cycles, then FETCH.
REQ-042 reset_n pulsed low during MEMWR → mem_write drops to 0 asynchronously, state=0, no instr_done.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS-style main controller: FSM sequencing, ALU decode, datapath selects.
// Optional MC_CONTROL_MEMWAIT_EN adds a mem_ready handshake with timeout abort.
module mc_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int ALU_CNTL_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [5:0]            op,
  input  logic [5:0]            func,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CNTL_W-1:0] alu_cntl,
  output logic [1:0]            pc_source,
  output logic [3:0]            state,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic                  mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic rt_ok(input logic [5:0] f);
    rt_ok = f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                      6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  endfunction

  function automatic logic [3:0] rt_alu(input logic [5:0] f);
    case (f)
      6'h20:   rt_alu = 4'b1010;
      6'h21:   rt_alu = 4'b0010;
      6'h22:   rt_alu = 4'b1110;
      6'h23:   rt_alu = 4'b0110;
      6'h24:   rt_alu = 4'b0000;
      6'h25:   rt_alu = 4'b0001;
      6'h26:   rt_alu = 4'b0011;
      6'h27:   rt_alu = 4'b1100;
      6'h2A:   rt_alu = 4'b1101;
      6'h2B:   rt_alu = 4'b1111;
      default: rt_alu = 4'b0000;
    endcase
  endfunction

  function automatic logic im_ok(input logic [5:0] o);
    im_ok = o inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B};
  endfunction

  function automatic logic [3:0] im_alu(input logic [5:0] o);
    case (o)
      6'h08:   im_alu = 4'b1010;
      6'h09:   im_alu = 4'b0010;
      6'h0C:   im_alu = 4'b0000;
      6'h0D:   im_alu = 4'b0001;
      6'h0A:   im_alu = 4'b1101;
      6'h0B:   im_alu = 4'b1111;
      default: im_alu = 4'b0000;
    endcase
  endfunction

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic [5:0] r_func;

  logic       w_pc_en;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [3:0] w_alu;
  logic [1:0] w_pc_source;
  logic       w_done;
  logic       w_illegal;
  logic       w_ready;
  logic       w_tmo;

`ifdef MC_CONTROL_MEMWAIT_EN
  logic [7:0] r_wait;
  logic       r_timeout;
  logic       w_mem_state;

  assign w_mem_state = (r_state == S_FETCH) ||
                       (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  assign w_ready = mem_ready;
  // Timeout fires on the MEM_WAIT_MAX-th consecutive cycle without ready.
  assign w_tmo   = w_mem_state && !mem_ready &&
                   (r_wait == 8'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_next != r_state || w_tmo)
        r_wait <= '0;
      else
        r_wait <= r_wait + 8'd1;
      if (w_tmo)
        r_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_timeout;
`else
  logic w_unused_ready;

  assign w_ready        = 1'b1;
  assign w_tmo          = 1'b0;
  assign w_unused_ready = ^{mem_ready, 8'(MEM_WAIT_MAX)};
  assign mem_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_op    <= '0;
      r_func  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op   <= op;
        r_func <= func;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_en      = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu        = 4'b0000;
    w_pc_source  = 2'b00;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_alu       = 4'b0010;
        if (w_ready) begin
          w_ir_write = 1'b1;
          w_pc_en    = 1'b1;
          w_next     = S_DECODE;
        end else if (w_tmo) begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu       = 4'b0010;
        unique case (1'b1)
          (op == OP_RTYPE) && rt_ok(func): w_next = S_RTEXE;
          im_ok(op):                       w_next = S_IEXE;
          (op == OP_LW) || (op == OP_SW):  w_next = S_MEMADR;
          (op == OP_BEQ) || (op == OP_BNE): w_next = S_BRANCH;
          (op == OP_J):                    w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu       = 4'b0010;
        w_next      = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (w_ready)
          w_next = S_MEMWB;
        else if (w_tmo)
          w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_done       = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (w_ready) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end else if (w_tmo) begin
          w_next = S_FETCH;
        end
      end
      S_RTEXE: begin
        w_alu_src_a = 1'b1;
        w_alu       = rt_alu(r_func);
        w_next      = S_RTWB;
      end
      S_RTWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu       = 4'b0110;
        w_pc_source = 2'b01;
        w_pc_en     = (r_op == OP_BEQ) ? zero : !zero;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_IEXE: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu       = im_alu(r_op);
        w_next      = S_IWB;
      end
      S_IWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_source = 2'b10;
        w_pc_en     = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are forced low combinationally so reset aborts writes at once.
  always_comb begin
    pc_en         = w_pc_en      & reset_n;
    iord          = w_iord       & reset_n;
    mem_read      = w_mem_read   & reset_n;
    mem_write     = w_mem_write  & reset_n;
    ir_write      = w_ir_write   & reset_n;
    mem_to_reg    = w_mem_to_reg & reset_n;
    reg_dst       = w_reg_dst    & reset_n;
    reg_write     = w_reg_write  & reset_n;
    alu_src_a     = w_alu_src_a  & reset_n;
    alu_src_b     = w_alu_src_b  & {2{reset_n}};
    alu_cntl      = '0;
    alu_cntl[3:0] = w_alu        & {4{reset_n}};
    pc_source     = w_pc_source  & {2{reset_n}};
    instr_done    = w_done       & reset_n;
    illegal_op    = w_illegal    & reset_n;
    state         = r_state;
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed, random and reset-abort scenarios
// against a path/table reference model of the controller.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_cntl;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_control #(.MEM_WAIT_MAX(15), .ALU_CNTL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_cntl(alu_cntl),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  logic [22:0] got;
  assign got = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_cntl,
                pc_source, state, instr_done, illegal_op};

  function automatic int alu_r(input logic [5:0] f);
    case (f)
      6'h20: return 10; 6'h21: return 2;  6'h22: return 14;
      6'h23: return 6;  6'h24: return 0;  6'h25: return 1;
      6'h26: return 3;  6'h27: return 12; 6'h2A: return 13;
      6'h2B: return 15;
      default: return -1;
    endcase
  endfunction

  function automatic int alu_i(input logic [5:0] o);
    case (o)
      6'h08: return 10; 6'h09: return 2;  6'h0C: return 0;
      6'h0D: return 1;  6'h0A: return 13; 6'h0B: return 15;
      default: return -1;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return alu_r(f) >= 0;
    return alu_i(o) >= 0 || o inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  endfunction

  function automatic logic [22:0] exp_vec(input int st, input logic [5:0] o,
                                          input logic [5:0] f, input logic z);
    logic pe, io, mr, mw, irw, m2r, rd, rw, a, dn, il;
    logic [1:0] b, ps;
    int alu;
    {pe, io, mr, mw, irw, m2r, rd, rw, a, dn, il} = '0;
    b = 0; ps = 0; alu = 0;
    case (st)
      0:  begin mr = 1; irw = 1; pe = 1; b = 1; alu = 2; end
      1:  begin b = 3; alu = 2; il = !legal(o, f); end
      2:  begin a = 1; b = 2; alu = 2; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; io = 1; dn = 1; end
      6:  begin a = 1; alu = alu_r(f); end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin a = 1; alu = 6; ps = 1; pe = (o == 6'h04) ? z : !z; dn = 1; end
      9:  begin a = 1; b = 2; alu = alu_i(o); end
      10: begin rw = 1; dn = 1; end
      11: begin ps = 2; pe = 1; dn = 1; end
      default: ;
    endcase
    return {pe, io, mr, mw, irw, m2r, rd, rw, a, b, 4'(alu), ps, 4'(st), dn, il};
  endfunction

  function automatic logic rdy();
`ifdef MC_CONTROL_MEMWAIT_EN
    return 1'b1;
`else
    return 1'($urandom);
`endif
  endfunction

  // Starts at posedge+1 with the DUT in FETCH; ends the same way.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input string name);
    int path[$];
    logic [22:0] e;
    if (o == 6'h00 && alu_r(f) >= 0)  path = '{0, 1, 6, 7};
    else if (alu_i(o) >= 0)           path = '{0, 1, 9, 10};
    else if (o == 6'h23)              path = '{0, 1, 2, 3, 4};
    else if (o == 6'h2B)              path = '{0, 1, 2, 5};
    else if (o inside {6'h04, 6'h05}) path = '{0, 1, 8};
    else if (o == 6'h02)              path = '{0, 1, 11};
    else                              path = '{0, 1};
    op = o; func = f; zero = z;
    foreach (path[i]) begin
      mem_ready = rdy();
      #3;
      e = exp_vec(path[i], o, f, z);
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s op=%h func=%h step%0d: got %h want %h",
                 name, o, f, i, got, e);
      end
      @(posedge clk); #1;
      if (path[i] == 1) begin
        op = 6'($urandom); func = 6'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; op = 6'h00; func = 6'h20; zero = 0; mem_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (got !== '0 || mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%b want 0/0", got, mem_timeout);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_instr(6'h00, 6'h20, 1'b0, "post_reset_add");
  endtask

  task automatic test_directed();
    run_instr(6'h00, 6'h20, 0, "add");
    run_instr(6'h23, 6'h00, 0, "lw");
    run_instr(6'h2B, 6'h11, 1, "sw");
    run_instr(6'h04, 6'h00, 1, "beq_taken");
    run_instr(6'h04, 6'h00, 0, "beq_not");
    run_instr(6'h05, 6'h00, 1, "bne_not");
    run_instr(6'h05, 6'h00, 0, "bne_taken");
    run_instr(6'h02, 6'h00, 0, "j");
    run_instr(6'h3F, 6'h20, 0, "illegal_op");
    run_instr(6'h00, 6'h3F, 0, "illegal_func");
    foreach (alu_i_ops[k]) run_instr(alu_i_ops[k], 6'h00, 0, "iop");
    foreach (r_funcs[k]) run_instr(6'h00, r_funcs[k], 0, "rfunc");
  endtask

  logic [5:0] alu_i_ops[6] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B};
  logic [5:0] r_funcs[10]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                               6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] ops[16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C,
                          6'h0D, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04,
                          6'h05, 6'h02, 6'h3F, 6'h01};

  task automatic test_random();
    logic [5:0] o, f;
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(15)];
      if (n % 7 == 3) o = 6'($urandom);
      f = ($urandom_range(4) == 0) ? 6'($urandom) : r_funcs[$urandom_range(9)];
      run_instr(o, f, 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_write();
    op = 6'h2B; func = 6'h00; zero = 0; mem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      bad++;
      $display("FAIL sw_reach_memwr: got st=%0d mw=%b want st=5 mw=1",
               state, mem_write);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (mem_write !== 1'b0 || state !== 4'd0 || instr_done !== 1'b0 ||
        got !== '0) begin
      bad++;
      $display("FAIL reset_mid_memwr: got %h want 0", got);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_instr(6'h00, 6'h22, 0, "after_abort");
  endtask

`ifdef MC_CONTROL_MEMWAIT_EN
  task automatic test_memwait();
    int n, low;
    bit seen;
    op = 6'h23; func = 0; zero = 0;
    mem_ready = 0; #2;
    total++;
    if (ir_write !== 0 || pc_en !== 0 || mem_read !== 1) begin
      bad++;
      $display("FAIL fetch_wait: got ir=%b pe=%b mr=%b want 0 0 1",
               ir_write, pc_en, mem_read);
    end
    @(posedge clk); #1;
    n = 0; low = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (state == 4'd3 && low < 3) begin mem_ready = 0; low++; end
      else mem_ready = 1;
      #2; n++;
      if (instr_done) seen = 1;
      @(posedge clk); #1;
    end
    total++;
    if (!seen || n != 8) begin
      bad++;
      $display("FAIL lw_wait3: got done=%b cycles=%0d want 1 8", seen, n);
    end
    n = 0; seen = 0; mem_ready = 1;
    for (int k = 0; k < 10 && state != 4'd3; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 40 && state == 4'd3; k++) begin
      mem_ready = 0; #2; n++;
      if (instr_done) seen = 1;
      @(posedge clk); #1;
    end
    mem_ready = 1;
    total++;
    if (n != 15 || seen || state !== 4'd0 || mem_timeout !== 1'b1) begin
      bad++;
      $display("FAIL lw_timeout: got cyc=%0d done=%b st=%0d to=%b want 15 0 0 1",
               n, seen, state, mem_timeout);
    end
    run_instr(6'h00, 6'h24, 0, "after_timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_write();
`ifdef MC_CONTROL_MEMWAIT_EN
    test_memwait();
`else
    total++;
    if (mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_tied: got %b want 0", mem_timeout);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
